uart_rx: RTL and testbench

- UART receive path: deserialises one asynchronous serial frame into a parallel byte.
- Frame format: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit.
- Oversamples RX_IN with a per-frame prescale and checks parity and stop bit.
- Sits between the pad-side serial line and the system-side consumer, mirroring the UART transmit path in frame format and parity conventions.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive path: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Optional 2-of-3 majority sampling per bit when UART_RX_MAJORITY_VOTE_EN is defined.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                  state_q;
  logic                    rx_meta_q, rx_s_q;
  logic [PRESCALE_W-1:0]   prescale_q, edge_cnt_q;
  logic                    par_en_q, par_type_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    samp_q, samp_vld_q;
  logic                    samp_d, samp_vld_d;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic                    data_valid_q, parity_error_q, stop_error_q, busy_q;
  logic [PRESCALE_W-1:0]   half;
  logic                    last_edge;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
  logic [1:0] vote_q;
`endif

  assign half      = prescale_q >> 1;
  assign last_edge = (edge_cnt_q == prescale_q - ONE);

  // The bit decision is registered and acted upon one cycle after it is formed.
  always_comb begin
    samp_d     = rx_s_q;
    samp_vld_d = 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    samp_d     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
    samp_vld_d = (state_q != IDLE) && (edge_cnt_q == half);
`else
    samp_vld_d = (state_q != IDLE) && (edge_cnt_q == half - ONE);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      prescale_q     <= '0;
      edge_cnt_q     <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      samp_q         <= 1'b1;
      samp_vld_q     <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      busy_q         <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q         <= '1;
`endif
    end else begin
      rx_meta_q    <= RX_IN;
      rx_s_q       <= rx_meta_q;
      samp_q       <= samp_d;
      samp_vld_q   <= samp_vld_d;
      data_valid_q <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (edge_cnt_q == half - TWO) vote_q[0] <= rx_s_q;
      if (edge_cnt_q == half - ONE) vote_q[1] <= rx_s_q;
`endif
      case (state_q)
        IDLE: begin
          edge_cnt_q <= '0;
          if (!rx_s_q) begin
            state_q        <= START;
            prescale_q     <= Prescale;
            par_en_q       <= parity_enable;
            par_type_q     <= parity_type;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b1;
          end
        end
        START: begin
          edge_cnt_q <= last_edge ? '0 : edge_cnt_q + ONE;
          if (samp_vld_q && samp_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (last_edge) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          edge_cnt_q <= last_edge ? '0 : edge_cnt_q + ONE;
          if (samp_vld_q) shift_q <= {samp_q, shift_q[DATA_WIDTH-1:1]};
          if (last_edge) begin
            if (bit_cnt_q == LAST_BIT) state_q <= par_en_q ? PARITY : STOP;
            else bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          edge_cnt_q <= last_edge ? '0 : edge_cnt_q + ONE;
          if (samp_vld_q && (samp_q != ((^shift_q) ^ par_type_q))) parity_error_q <= 1'b1;
          if (last_edge) state_q <= STOP;
        end
        STOP: begin
          edge_cnt_q <= last_edge ? '0 : edge_cnt_q + ONE;
          // Leave at mid-stop so a start bit directly after the stop bit is not missed.
          if (samp_vld_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!samp_q) begin
              stop_error_q <= 1'b1;
            end else if (!parity_error_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are scheduled as per-cycle expected output events and checked every cycle.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int XTRA = 1;
  localparam bit MAJ  = 1'b1;
`else
  localparam int XTRA = 0;
  localparam bit MAJ  = 1'b0;
`endif
  localparam int MAXC = 40000;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, parity_enable, parity_type;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid, parity_error, stop_error, busy;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .P_DATA(P_DATA), .data_valid(data_valid), .parity_error(parity_error),
    .stop_error(stop_error), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  bit cmp_en = 1'b0;

  // Expected-output events keyed by the clock edge after which they take effect (-1 = none).
  int ev_busy[MAXC], ev_pe[MAXC], ev_se[MAXC], ev_pd[MAXC];
  bit ev_dv[MAXC], ev_rst[MAXC];

  int m_busy = 0, m_pe = 0, m_se = 0, m_pd = 0;
  int last_dv_cyc = -1, dv_count = 0;
  logic [7:0] dv_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin : cmp
    int c;
    bit exp_dv;
    if (cmp_en && cyc < MAXC) begin
      c = int'(cyc);
      exp_dv = 1'b0;
      if (ev_rst[c]) begin
        m_busy = 0; m_pe = 0; m_se = 0; m_pd = 0;
      end else begin
        if (ev_busy[c] >= 0) m_busy = ev_busy[c];
        if (ev_pe[c]   >= 0) m_pe   = ev_pe[c];
        if (ev_se[c]   >= 0) m_se   = ev_se[c];
        if (ev_pd[c]   >= 0) m_pd   = ev_pd[c];
        exp_dv = ev_dv[c];
      end
      check("data_valid",   data_valid,   exp_dv);
      check("busy",         busy,         m_busy);
      check("parity_error", parity_error, m_pe);
      check("stop_error",   stop_error,   m_se);
      check("P_DATA",       P_DATA,       m_pd);
      if (data_valid === 1'b1) begin
        last_dv_cyc = c;
        dv_count++;
        dv_hist.push_back(P_DATA);
      end
    end
  end

  initial begin : watchdog
    #((MAXC - 20) * 10);
    n_err++;
    $display("FAIL watchdog: cycle budget exhausted at cyc=%0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic hold(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [5:0] rand_ps();
    int r;
    r = $urandom_range(2);
    return (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : 6'd32;
  endfunction

  task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                            input bit bad_par, input bit stop_low, input int gap,
                            input int abort_bit, input int spike_bit, output int L);
    int c, s, e, nb, c2;
    logic [7:0] rd;
    logic v;
    bit ok;
    Prescale = 6'(p); parity_enable = pe; parity_type = pt;
    c  = int'(cyc);
    L  = c + 1;
    s  = c + 3;
    nb = 9 + int'(pe);
    e  = s + nb * p + p / 2 + 1 + XTRA;
    rd = d;
    if (spike_bit >= 0 && !MAJ) rd[spike_bit] = ~rd[spike_bit];
    ok = !bad_par && !stop_low;
    ev_busy[s] = 1; ev_pe[s] = 0; ev_se[s] = 0;
    if (pe) ev_pe[s + 9 * p + p / 2 + 1 + XTRA] = int'(bad_par);
    ev_busy[e] = 0;
    ev_se[e]   = int'(stop_low);
    if (ok) begin
      ev_dv[e] = 1'b1;
      ev_pd[e] = int'(rd);
    end
    hold(1'b0, 4);
    // Configuration must already be latched; disturb it for the rest of the frame.
    Prescale = rand_ps(); parity_enable = 1'($urandom); parity_type = 1'($urandom);
    hold(1'b0, p - 4);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        c2 = int'(cyc);
        RST = 1'b1; RX_IN = 1'b1;
        for (int k = c2 + 1; k <= e + 1; k++) begin
          ev_busy[k] = -1; ev_pe[k] = -1; ev_se[k] = -1; ev_pd[k] = -1;
          ev_dv[k] = 1'b0; ev_rst[k] = 1'b0;
        end
        ev_rst[c2 + 1] = 1'b1;
        @(negedge CLK);
        check("abort_busy", busy, 0);
        check("abort_P_DATA", P_DATA, 0);
        check("abort_flags", {parity_error, stop_error, data_valid}, 0);
        RST = 1'b0;
        hold(1'b1, gap);
        return;
      end
      v = d[i];
      if (i == spike_bit) begin
        hold(v, p / 2); hold(~v, 1); hold(v, p / 2 - 1);
      end else begin
        hold(v, p);
      end
    end
    if (pe) hold((^d) ^ pt ^ bad_par, p);
    if (stop_low) begin
      hold(1'b0, p / 2 + 2); hold(1'b1, p / 2 - 2);
    end else begin
      hold(1'b1, p);
    end
    hold(1'b1, gap);
  endtask

  initial begin : main
    int L, n0, s;
    int p, gap;
    bit pe, pt, bp, sl;
    for (int i = 0; i < MAXC; i++) begin
      ev_busy[i] = -1; ev_pe[i] = -1; ev_se[i] = -1; ev_pd[i] = -1;
      ev_dv[i] = 1'b0; ev_rst[i] = 1'b0;
    end
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_P_DATA", P_DATA, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_parity_error", parity_error, 0);
    check("rst_stop_error", stop_error, 0);
    check("rst_busy", busy, 0);
    cmp_en = 1'b1;
    RST = 1'b0;
    hold(1'b1, 5);

    n0 = dv_count;
    send_frame(8, 0, 0, 8'hA5, 0, 0, 8, -1, -1, L);
    check("t1_latency", last_dv_cyc - L, 79 + XTRA);
    check("t1_P_DATA", P_DATA, 8'hA5);
    check("t1_dv_count", dv_count - n0, 1);
    check("t1_flags", {parity_error, stop_error}, 0);

    send_frame(16, 1, 0, 8'h3C, 0, 0, 8, -1, -1, L);
    check("t2_P_DATA", P_DATA, 8'h3C);
    check("t2_parity_error", parity_error, 0);
    n0 = dv_count;
    send_frame(16, 1, 0, 8'h3C, 1, 0, 8, -1, -1, L);
    check("t2b_parity_error", parity_error, 1);
    check("t2b_no_dv", dv_count - n0, 0);
    check("t2b_P_DATA_kept", P_DATA, 8'h3C);

    n0 = dv_count;
    send_frame(32, 1, 1, 8'h00, 0, 1, 8, -1, -1, L);
    check("t3_stop_error", stop_error, 1);
    check("t3_parity_error", parity_error, 0);
    check("t3_no_dv", dv_count - n0, 0);

    Prescale = 6'd8; parity_enable = 1'b0;
    n0 = dv_count;
    s = int'(cyc) + 3;
    ev_busy[s] = 1; ev_pe[s] = 0; ev_se[s] = 0;
    ev_busy[s + 5 + XTRA] = 0;
    hold(1'b0, 3);
    hold(1'b1, 8);
    check("t4_busy_low", busy, 0);
    check("t4_no_dv", dv_count - n0, 0);
    check("t4_flags", {parity_error, stop_error}, 0);

    n0 = dv_count;
    send_frame(8, 0, 0, 8'h55, 0, 0, 0, -1, -1, L);
    send_frame(8, 0, 0, 8'hAA, 0, 0, 8, -1, -1, L);
    check("t5_dv_count", dv_count - n0, 2);
    check("t5_first", dv_hist[dv_hist.size() - 2], 8'h55);
    check("t5_second", dv_hist[dv_hist.size() - 1], 8'hAA);

    send_frame(8, 0, 0, 8'hFF, 0, 0, 10, 3, -1, L);
    send_frame(8, 0, 0, 8'h81, 0, 0, 8, -1, -1, L);
    check("t6_P_DATA", P_DATA, 8'h81);

    send_frame(16, 0, 0, 8'h81, 0, 0, 8, -1, 3, L);
    check("t7_spike", P_DATA, MAJ ? 8'h81 : 8'h89);

    for (int n = 0; n < 40; n++) begin
      p   = int'(rand_ps());
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      bp  = pe && ($urandom_range(3) == 0);
      sl  = ($urandom_range(3) == 0);
      gap = int'($urandom_range(2 * p));
      send_frame(p, pe, pt, 8'($urandom), bp, sl, gap, -1, -1, L);
    end
    hold(1'b1, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
